// File: rtl/vend_bus_sequencer.sv
// Avalon-MM write master for the vending register slave: expands queued panel events
// into assert/hold/clear write sequences and round-robins the port with a host writer.
module vend_bus_sequencer #(
  parameter int HOLD_CYC   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ev_valid,
  input  logic [2:0] ev_code,
  input  logic [2:0] ev_arg,
  output logic       ev_ready,
  input  logic       host_req,
  input  logic [3:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic       host_gnt,
  output logic       av_chipselect,
  output logic       av_write,
  output logic [3:0] av_address,
  output logic [7:0] av_writedata,
  output logic       busy,
  output logic [2:0] ev_count,
  output logic       err_illegal
);
  // state    | meaning
  // IDLE     | arbitrate between queue head and host request
  // HOST     | host write on the bus, host_gnt high
  // ASSERT   | event register written with its asserted value
  // HOLD     | pulse register held, hold counter running down
  // DEASSERT | pulse register written back to 0
  typedef enum logic [2:0] {IDLE, HOST, ASSERT, HOLD, DEASSERT} state_t;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [5:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop;

  state_t     state, state_d;
  logic [3:0] cnt, cnt_d;
  logic [3:0] seq_addr, seq_addr_d;
  logic       seq_level, seq_level_d;
  logic       last_host, last_host_d;
  logic       wr_d, gnt_d, err_d;
  logic [3:0] addr_d;
  logic [7:0] data_d;

  logic [2:0] head_code, head_arg;
  logic       dec_legal, dec_level;
  logic [3:0] dec_addr;
  logic [7:0] dec_data;

  assign ev_ready  = (count != CNT_W'(FIFO_DEPTH));
  assign push      = ev_valid & ev_ready;
  assign ev_count  = 3'(count);
  assign busy      = (state != IDLE) || (count != '0);
  assign head_code = mem[rd_ptr][5:3];
  assign head_arg  = mem[rd_ptr][2:0];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {ev_code, ev_arg};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    dec_legal = 1'b1;
    dec_level = 1'b0;
    dec_addr  = 4'd0;
    dec_data  = 8'd0;
    case (head_code)
      3'd0: begin
        dec_level = 1'b1;
        dec_data  = {5'b0, head_arg};
        dec_legal = (head_arg == 3'b001) || (head_arg == 3'b010) || (head_arg == 3'b100);
      end
      3'd1: begin
        dec_addr  = 4'd1;
        dec_data  = {5'b0, head_arg};
        dec_legal = (head_arg == 3'b001) || (head_arg == 3'b010) || (head_arg == 3'b100);
      end
      3'd2: begin dec_addr = 4'd2; dec_data = 8'd1; end
      3'd3: begin dec_addr = 4'd3; dec_data = 8'd1; end
      3'd4: begin dec_addr = 4'd4; dec_data = 8'd1; end
      3'd5: dec_level = 1'b1;
      default: dec_legal = 1'b0;
    endcase
  end

  // Bus outputs are computed for the next state and registered, so a write
  // appears in the same cycle the FSM occupies its write state.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    seq_addr_d  = seq_addr;
    seq_level_d = seq_level;
    last_host_d = last_host;
    pop         = 1'b0;
    wr_d        = 1'b0;
    gnt_d       = 1'b0;
    err_d       = 1'b0;
    addr_d      = 4'd0;
    data_d      = 8'd0;
    case (state)
      IDLE: begin
        if ((count != '0) && (!host_req || last_host)) begin
          pop         = 1'b1;
          last_host_d = 1'b0;
          if (dec_legal) begin
            state_d     = ASSERT;
            wr_d        = 1'b1;
            addr_d      = dec_addr;
            data_d      = dec_data;
            seq_addr_d  = dec_addr;
            seq_level_d = dec_level;
            cnt_d       = 4'(HOLD_CYC);
          end else begin
            err_d = 1'b1;
          end
        end else if (host_req) begin
          state_d     = HOST;
          last_host_d = 1'b1;
          wr_d        = 1'b1;
          gnt_d       = 1'b1;
          addr_d      = host_addr;
          data_d      = host_wdata;
        end
      end
      HOST:     state_d = IDLE;
      ASSERT:   state_d = seq_level ? IDLE : HOLD;
      HOLD: begin
        if (cnt == 4'd1) begin
          state_d = DEASSERT;
          wr_d    = 1'b1;
          addr_d  = seq_addr;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      DEASSERT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      seq_addr      <= 4'd0;
      seq_level     <= 1'b0;
      last_host     <= 1'b1;
      av_write      <= 1'b0;
      av_chipselect <= 1'b0;
      av_address    <= 4'd0;
      av_writedata  <= 8'd0;
      host_gnt      <= 1'b0;
      err_illegal   <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      seq_addr      <= seq_addr_d;
      seq_level     <= seq_level_d;
      last_host     <= last_host_d;
      av_write      <= wr_d;
      av_chipselect <= wr_d;
      av_address    <= addr_d;
      av_writedata  <= data_d;
      host_gnt      <= gnt_d;
      err_illegal   <= err_d;
    end
  end
endmodule

// File: tb/tb_vend_bus_sequencer.sv
// Scoreboard bench for vend_bus_sequencer: stimulus queues expected writes,
// a negedge monitor pops and compares every bus write.
module tb_vend_bus_sequencer;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       ev_valid;
  logic [2:0] ev_code, ev_arg;
  logic       ev_ready;
  logic       host_req;
  logic [3:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_gnt;
  logic       av_chipselect, av_write;
  logic [3:0] av_address;
  logic [7:0] av_writedata;
  logic       busy;
  logic [2:0] ev_count;
  logic       err_illegal;

  vend_bus_sequencer #(.HOLD_CYC(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .ev_valid(ev_valid), .ev_code(ev_code), .ev_arg(ev_arg), .ev_ready(ev_ready),
    .host_req(host_req), .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt),
    .av_chipselect(av_chipselect), .av_write(av_write), .av_address(av_address),
    .av_writedata(av_writedata), .busy(busy), .ev_count(ev_count), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    logic       host;
    int         at;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0, checks = 0, err_pulses = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (err_illegal) err_pulses++;
      if (av_write) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0d data %0h at cycle %0d, none expected",
                   av_address, av_writedata, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", av_address, mon_e.addr);
          check("wr_data", av_writedata, mon_e.data);
          check("wr_host_gnt", host_gnt, mon_e.host);
          check("wr_chipselect", av_chipselect, 1);
          if (mon_e.at >= 0) check("wr_cycle", cyc, mon_e.at);
        end
      end else if (av_chipselect || host_gnt || av_address != 4'd0 || av_writedata != 8'd0) begin
        checks++;
        errors++;
        $display("FAIL idle_bus: cs %0d gnt %0d addr %0d data %0h, required all 0 at cycle %0d",
                 av_chipselect, host_gnt, av_address, av_writedata, cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_wr(input logic [3:0] a, input logic [7:0] d, input logic h, input int at);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.host = h;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic push_ev(input logic [2:0] c, input logic [2:0] a, output int acc);
    int n = 0;
    ev_valid = 1'b1;
    ev_code  = c;
    ev_arg   = a;
    while (!ev_ready && n < 100) begin
      tick(1);
      n++;
    end
    if (!ev_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: ev_ready stayed 0, required 1 within 100 cycles");
    end
    acc = cyc;
    tick(1);
    ev_valid = 1'b0;
    ev_code  = 3'd0;
    ev_arg   = 3'd0;
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    int n = 0;
    host_req   = 1'b1;
    host_addr  = a;
    host_wdata = d;
    while (!host_gnt && n < 100) begin
      tick(1);
      n++;
    end
    if (!host_gnt) begin
      checks++;
      errors++;
      $display("FAIL host_timeout: host_gnt stayed 0, required 1 within 100 cycles");
    end
    host_req   = 1'b0;
    host_addr  = 4'd0;
    host_wdata = 8'd0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 200) begin
      tick(1);
      n++;
    end
    tick(2);
    check("drain_expected", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  initial begin
    int t, acc, e0;
    reset_n    = 1'b0;
    ev_valid   = 1'b0;
    ev_code    = 3'd0;
    ev_arg     = 3'd0;
    host_req   = 1'b0;
    host_addr  = 4'd0;
    host_wdata = 8'd0;
    tick(2);
    check("rst_av_write", av_write, 0);
    check("rst_av_cs", av_chipselect, 0);
    check("rst_av_addr", av_address, 0);
    check("rst_av_data", av_writedata, 0);
    check("rst_host_gnt", host_gnt, 0);
    check("rst_err", err_illegal, 0);
    check("rst_busy", busy, 0);
    check("rst_ev_count", ev_count, 0);
    check("rst_ev_ready", ev_ready, 1);
    reset_n = 1'b1;
    tick(1);

    // coin: assert at t+2, clear at t+7
    t = cyc;
    expect_wr(4'd1, 8'h02, 1'b0, t + 2);
    expect_wr(4'd1, 8'h00, 1'b0, t + 7);
    push_ev(3'd1, 3'b010, acc);
    check("coin_accept_cycle", acc, t);
    wait_idle();

    // full flow
    expect_wr(4'd0, 8'h02, 1'b0, -1);
    expect_wr(4'd1, 8'h04, 1'b0, -1);
    expect_wr(4'd1, 8'h00, 1'b0, -1);
    expect_wr(4'd1, 8'h04, 1'b0, -1);
    expect_wr(4'd1, 8'h00, 1'b0, -1);
    expect_wr(4'd3, 8'h01, 1'b0, -1);
    expect_wr(4'd3, 8'h00, 1'b0, -1);
    expect_wr(4'd4, 8'h01, 1'b0, -1);
    expect_wr(4'd4, 8'h00, 1'b0, -1);
    push_ev(3'd0, 3'b010, acc);
    push_ev(3'd1, 3'b100, acc);
    push_ev(3'd1, 3'b100, acc);
    push_ev(3'd3, 3'b000, acc);
    push_ev(3'd4, 3'b000, acc);
    wait_idle();

    // illegal events
    e0 = err_pulses;
    push_ev(3'd1, 3'b011, acc);
    push_ev(3'd7, 3'b000, acc);
    wait_idle();
    check("illegal_pulses", err_pulses - e0, 2);
    check("illegal_ev_count", ev_count, 0);
    check("illegal_busy", busy, 0);

    // arbitration: queue first from reset, then alternation
    do_reset();
    expect_wr(4'd2, 8'h01, 1'b0, -1);
    expect_wr(4'd2, 8'h00, 1'b0, -1);
    expect_wr(4'd5, 8'hA5, 1'b1, -1);
    push_ev(3'd2, 3'b000, acc);
    host_write(4'd5, 8'hA5);
    wait_idle();
    expect_wr(4'd0, 8'h01, 1'b0, -1);
    expect_wr(4'd7, 8'h11, 1'b1, -1);
    expect_wr(4'd0, 8'h04, 1'b0, -1);
    push_ev(3'd0, 3'b001, acc);
    push_ev(3'd0, 3'b100, acc);
    host_write(4'd7, 8'h11);
    wait_idle();

    // full queue while stalled in HOLD
    t = cyc;
    expect_wr(4'd1, 8'h01, 1'b0, t + 2);
    expect_wr(4'd1, 8'h00, 1'b0, t + 7);
    expect_wr(4'd0, 8'h01, 1'b0, -1);
    expect_wr(4'd0, 8'h00, 1'b0, -1);
    expect_wr(4'd2, 8'h01, 1'b0, -1);
    expect_wr(4'd2, 8'h00, 1'b0, -1);
    expect_wr(4'd0, 8'h02, 1'b0, -1);
    expect_wr(4'd0, 8'h04, 1'b0, -1);
    push_ev(3'd1, 3'b001, acc);
    push_ev(3'd0, 3'b001, acc);
    push_ev(3'd5, 3'b000, acc);
    push_ev(3'd2, 3'b000, acc);
    push_ev(3'd0, 3'b010, acc);
    check("full_ev_count", ev_count, 4);
    check("full_ev_ready", ev_ready, 0);
    push_ev(3'd0, 3'b100, acc);
    check("held_accept_cycle", acc, t + 9);
    wait_idle();

    // reset in HOLD abandons the clear write
    t = cyc;
    expect_wr(4'd1, 8'h04, 1'b0, t + 2);
    push_ev(3'd1, 3'b100, acc);
    push_ev(3'd0, 3'b001, acc);
    tick(2);
    check("pre_reset_ev_count", ev_count, 1);
    reset_n = 1'b0;
    #1;
    check("hold_rst_av_write", av_write, 0);
    check("hold_rst_av_cs", av_chipselect, 0);
    check("hold_rst_av_addr", av_address, 0);
    check("hold_rst_ev_count", ev_count, 0);
    check("hold_rst_busy", busy, 0);
    tick(2);
    reset_n = 1'b1;
    tick(15);
    check("post_reset_no_writes", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end
endmodule
